// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-step multiply / restoring-divide sequencer feeding
// the HI/LO register pair. Operands are converted to magnitudes on accept;
// sign correction of the result is applied in a single FIX cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hilo_wr,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;   // negate product / quotient
  logic               neg_r;   // negate remainder (dividend was negative)
  logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;     // {hi_acc, multiplier} or {rem, quot}

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   trial;
  logic               ge;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // operand magnitudes; |most-negative| stays as the unsigned value 2^(W-1)
  always_comb begin
    sgn_a = is_signed & a[WIDTH-1];
    sgn_b = is_signed & b[WIDTH-1];
    abs_a = sgn_a ? -a : a;
    abs_b = sgn_b ? -b : b;
  end

  // one shift-add or restoring-divide iteration
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = rem_sh >= {1'b0, opnd};
    // true difference is below the divisor when ge, so W bits suffice
    trial   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div)
      acc_nxt = {(ge ? trial : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    else
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // final sign correction
  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hilo_wr  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          is_div   <= op_div;
          neg_q    <= sgn_a ^ sgn_b;
          neg_r    <= sgn_a & op_div;
          cnt      <= '0;
          busy     <= 1'b1;
          div_zero <= 1'b0;
          if (op_div && b == '0) begin
            // no iterations; hi/lo keep their previous contents
            div_zero <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            opnd  <= op_div ? abs_b : abs_a;
            acc   <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          hi      <= res_hi;
          lo      <= res_lo;
          done    <= 1'b1;
          hilo_wr <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          hilo_wr <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
